// File: rtl/exc_flush_ctrl_pkg.sv
// Shared exception codes, subcodes and FSM encoding for the commit-point
// exception / ERTN flush controller.
package exc_flush_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUB_NONE = 9'd0;
    localparam logic [8:0] ESUB_ADEF = 9'd0;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_INT  = 2'd1,
        WIN_EXC  = 2'd2,
        WIN_ERTN = 2'd3
    } win_e;

endpackage

// File: rtl/exc_flush_ctrl_prio_sel.sv
// Combinational winner selection for a committing WB instruction:
// interrupt beats instruction exception beats ERTN.
module exc_prio_sel #(
    parameter logic [5:0] ECODE_INT = 6'h00
) (
    input  logic       en_i,
    input  logic       valid_i,
    input  logic       int_i,
    input  logic       ex_i,
    input  logic [5:0] ecode_i,
    input  logic [8:0] esub_i,
    input  logic       ertn_i,
    output logic       commit_o,
    output logic       take_ex_o,
    output logic       take_ertn_o,
    output logic [5:0] ecode_o,
    output logic [8:0] esub_o
);
    import exc_flush_ctrl_pkg::*;

    win_e win;

    always_comb begin
        win = WIN_NONE;
        if (en_i && valid_i) begin
            if (int_i)       win = WIN_INT;
            else if (ex_i)   win = WIN_EXC;
            else if (ertn_i) win = WIN_ERTN;
        end
    end

    // Code fields are forced to zero unless an exception strobe is issued.
    always_comb begin
        commit_o    = 1'b0;
        take_ex_o   = 1'b0;
        take_ertn_o = 1'b0;
        ecode_o     = 6'h00;
        esub_o      = ESUB_NONE;
        case (win)
            WIN_INT: begin
                commit_o  = 1'b1;
                take_ex_o = 1'b1;
                ecode_o   = ECODE_INT;
                esub_o    = ESUB_NONE;
            end
            WIN_EXC: begin
                commit_o  = 1'b1;
                take_ex_o = 1'b1;
                ecode_o   = ecode_i;
                esub_o    = esub_i;
            end
            WIN_ERTN: begin
                commit_o    = 1'b1;
                take_ertn_o = 1'b1;
            end
            default: begin
                commit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Commit-point controller: fuses interrupts with WB exceptions, strobes the
// CSR file, then holds the pipeline flushed until fetch accepts the redirect.
module exc_flush_ctrl #(
    parameter logic [5:0]  ECODE_INT = 6'h00,
    parameter int unsigned IRQ_W     = 13
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_valid,
    input  logic [31:0]      wb_pc,
    input  logic             wb_ex_in,
    input  logic [5:0]       wb_ecode_in,
    input  logic [8:0]       wb_esub_in,
    input  logic [31:0]      wb_vaddr_in,
    input  logic             wb_is_ertn,
    output logic             wb_ready,
    input  logic             csr_crmd_ie,
    input  logic [IRQ_W-1:0] csr_estat_is,
    input  logic [IRQ_W-1:0] csr_ecfg_lie,
    input  logic [31:0]      csr_ex_entry,
    input  logic [31:0]      csr_ertn_entry,
    output logic             wb_ex,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [31:0]      wb_csr_pc,
    output logic [31:0]      wb_vaddr,
    output logic             ertn_flush,
    output logic             flush_all,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready
);
    import exc_flush_ctrl_pkg::*;

    state_e      state_q, state_d;
    logic        int_sync_q;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        int_raw;
    logic        in_idle;
    logic        commit;
    logic        take_ex;
    logic        take_ertn;
    logic [5:0]  sel_ecode;
    logic [8:0]  sel_esub;

    assign int_raw = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
    assign in_idle = (state_q == ST_IDLE);

    exc_prio_sel #(
        .ECODE_INT (ECODE_INT)
    ) u_prio_sel (
        .en_i        (in_idle),
        .valid_i     (wb_valid),
        .int_i       (int_sync_q),
        .ex_i        (wb_ex_in),
        .ecode_i     (wb_ecode_in),
        .esub_i      (wb_esub_in),
        .ertn_i      (wb_is_ertn),
        .commit_o    (commit),
        .take_ex_o   (take_ex),
        .take_ertn_o (take_ertn),
        .ecode_o     (sel_ecode),
        .esub_o      (sel_esub)
    );

    // The redirect target samples the CSR entries before the strobe lands,
    // so a commit that rewrites ERA/EENTRY cannot affect its own redirect.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = take_ex ? csr_ex_entry : csr_ertn_entry;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            int_sync_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            int_sync_q    <= int_raw;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign wb_ex          = take_ex;
    assign ertn_flush     = take_ertn;
    assign wb_ecode       = sel_ecode;
    assign wb_esubcode    = sel_esub;
    assign wb_csr_pc      = commit ? wb_pc : 32'h0;
    assign wb_vaddr       = commit ? wb_vaddr_in : 32'h0;
    assign flush_all      = commit | ~in_idle;
    assign redirect_valid = ~in_idle;
    assign redirect_pc    = redirect_pc_q;
    assign wb_ready       = in_idle;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Bench for exc_flush_ctrl: directed scenarios from the block's test plan plus
// a randomized run against a cycle-level behavioural model.
module tb_exc_flush_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_ex_in;
    logic [5:0]  wb_ecode_in;
    logic [8:0]  wb_esub_in;
    logic [31:0] wb_vaddr_in;
    logic        wb_is_ertn;
    logic        wb_ready;
    logic        csr_crmd_ie;
    logic [12:0] csr_estat_is;
    logic [12:0] csr_ecfg_lie;
    logic [31:0] csr_ex_entry;
    logic [31:0] csr_ertn_entry;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_csr_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        flush_all;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exc_flush_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_ex_in       (wb_ex_in),
        .wb_ecode_in    (wb_ecode_in),
        .wb_esub_in     (wb_esub_in),
        .wb_vaddr_in    (wb_vaddr_in),
        .wb_is_ertn     (wb_is_ertn),
        .wb_ready       (wb_ready),
        .csr_crmd_ie    (csr_crmd_ie),
        .csr_estat_is   (csr_estat_is),
        .csr_ecfg_lie   (csr_ecfg_lie),
        .csr_ex_entry   (csr_ex_entry),
        .csr_ertn_entry (csr_ertn_entry),
        .wb_ex          (wb_ex),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_csr_pc      (wb_csr_pc),
        .wb_vaddr       (wb_vaddr),
        .ertn_flush     (ertn_flush),
        .flush_all      (flush_all),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        resetn         = 1'b1;
        wb_valid       = 1'b0;
        wb_pc          = 32'h0;
        wb_ex_in       = 1'b0;
        wb_ecode_in    = 6'h0;
        wb_esub_in     = 9'h0;
        wb_vaddr_in    = 32'h0;
        wb_is_ertn     = 1'b0;
        csr_crmd_ie    = 1'b0;
        csr_estat_is   = 13'h0;
        csr_ecfg_lie   = 13'h0;
        csr_ex_entry   = 32'h0;
        csr_ertn_entry = 32'h0;
        redirect_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%0b exp=0", redirect_valid); end
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0b exp=0", flush_all); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", wb_ready); end
        checks++; if (wb_ex !== 1'b0 || ertn_flush !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%0b%0b exp=00", wb_ex, ertn_flush); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got=%08h exp=00000000", redirect_pc); end
        $display("reset: rv=%0b flush=%0b ready=%0b", redirect_valid, flush_all, wb_ready);
        tick();
    endtask

    task automatic test_syscall();
        idle_inputs();
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = 6'h0B;
        wb_pc = 32'h1c000100; csr_ex_entry = 32'h1c008000; csr_ertn_entry = 32'h1c00dead;
        @(negedge clk);
        checks++; if (wb_ex !== 1'b1) begin errors++; $display("FAIL sys_wb_ex got=%0b exp=1", wb_ex); end
        checks++; if (ertn_flush !== 1'b0) begin errors++; $display("FAIL sys_ertn got=%0b exp=0", ertn_flush); end
        checks++; if (wb_ecode !== 6'h0B) begin errors++; $display("FAIL sys_ecode got=%02h exp=0b", wb_ecode); end
        checks++; if (wb_csr_pc !== 32'h1c000100) begin errors++; $display("FAIL sys_pc got=%08h exp=1c000100", wb_csr_pc); end
        checks++; if (flush_all !== 1'b1) begin errors++; $display("FAIL sys_flush got=%0b exp=1", flush_all); end
        $display("syscall: commit pc=%08h ecode=%02h", wb_csr_pc, wb_ecode);
        tick();
        wb_valid = 1'b0; wb_ex_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            csr_ex_entry = 32'h1c00f000 + 32'(i);
            @(negedge clk);
            checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL sys_rv[%0d] got=%0b exp=1", i, redirect_valid); end
            checks++; if (redirect_pc !== 32'h1c008000) begin errors++; $display("FAIL sys_rpc[%0d] got=%08h exp=1c008000", i, redirect_pc); end
            checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL sys_ready[%0d] got=%0b exp=0", i, wb_ready); end
            checks++; if (wb_ex !== 1'b0 || flush_all !== 1'b1) begin errors++; $display("FAIL sys_hold[%0d] wb_ex=%0b flush=%0b exp=0,1", i, wb_ex, flush_all); end
            tick();
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL sys_rv_accept got=%0b exp=1", redirect_valid); end
        tick();
        redirect_ready = 1'b0;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0 || wb_ready !== 1'b1 || flush_all !== 1'b0) begin errors++; $display("FAIL sys_idle rv=%0b ready=%0b flush=%0b exp=0,1,0", redirect_valid, wb_ready, flush_all); end
        tick();
    endtask

    task automatic test_ertn();
        idle_inputs();
        wb_valid = 1'b1; wb_is_ertn = 1'b1; wb_pc = 32'h1c000300;
        csr_ertn_entry = 32'h1c000104; csr_ex_entry = 32'h1c008000;
        @(negedge clk);
        checks++; if (ertn_flush !== 1'b1) begin errors++; $display("FAIL ertn_strobe got=%0b exp=1", ertn_flush); end
        checks++; if (wb_ex !== 1'b0) begin errors++; $display("FAIL ertn_wb_ex got=%0b exp=0", wb_ex); end
        $display("ertn: commit pc=%08h", wb_pc);
        tick();
        idle_inputs();
        redirect_ready = 1'b1;
        @(negedge clk);
        checks++; if (redirect_pc !== 32'h1c000104 || redirect_valid !== 1'b1) begin errors++; $display("FAIL ertn_rpc got=%08h rv=%0b exp=1c000104,1", redirect_pc, redirect_valid); end
        checks++; if (ertn_flush !== 1'b0) begin errors++; $display("FAIL ertn_once got=%0b exp=0", ertn_flush); end
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_int_priority();
        idle_inputs();
        csr_crmd_ie = 1'b1; csr_estat_is = 13'h0800; csr_ecfg_lie = 13'h0800;
        @(negedge clk);
        checks++; if (wb_ex !== 1'b0 || flush_all !== 1'b0) begin errors++; $display("FAIL intp_idle wb_ex=%0b flush=%0b exp=0,0", wb_ex, flush_all); end
        tick();
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = 6'h0D; wb_esub_in = 9'h05;
        wb_pc = 32'h1c000200; csr_ex_entry = 32'h1c008000;
        @(negedge clk);
        checks++; if (wb_ex !== 1'b1) begin errors++; $display("FAIL intp_wb_ex got=%0b exp=1", wb_ex); end
        checks++; if (wb_ecode !== 6'h00) begin errors++; $display("FAIL intp_ecode got=%02h exp=00", wb_ecode); end
        checks++; if (wb_esubcode !== 9'h000) begin errors++; $display("FAIL intp_esub got=%03h exp=000", wb_esubcode); end
        checks++; if (wb_csr_pc !== 32'h1c000200) begin errors++; $display("FAIL intp_pc got=%08h exp=1c000200", wb_csr_pc); end
        $display("int_priority: commit pc=%08h ecode=%02h", wb_csr_pc, wb_ecode);
        tick();
        idle_inputs();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_int_mask_timing();
        idle_inputs();
        csr_crmd_ie = 1'b1; csr_estat_is = 13'h0004; csr_ecfg_lie = 13'h0000;
        wb_valid = 1'b1; wb_pc = 32'h1c000400;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (wb_ex !== 1'b0 || flush_all !== 1'b0) begin errors++; $display("FAIL mask_off[%0d] wb_ex=%0b flush=%0b exp=0,0", i, wb_ex, flush_all); end
            tick();
        end
        csr_ecfg_lie = 13'h0004;
        @(negedge clk);
        checks++; if (wb_ex !== 1'b0) begin errors++; $display("FAIL mask_cycle_n got=%0b exp=0", wb_ex); end
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        checks++; if (wb_ex !== 1'b0 || flush_all !== 1'b0) begin errors++; $display("FAIL mask_novalid wb_ex=%0b flush=%0b exp=0,0", wb_ex, flush_all); end
        tick();
        wb_valid = 1'b1; wb_pc = 32'h1c000408; csr_ex_entry = 32'h1c008000;
        @(negedge clk);
        checks++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h00) begin errors++; $display("FAIL mask_taken wb_ex=%0b ecode=%02h exp=1,00", wb_ex, wb_ecode); end
        checks++; if (wb_csr_pc !== 32'h1c000408) begin errors++; $display("FAIL mask_pc got=%08h exp=1c000408", wb_csr_pc); end
        $display("int_timing: commit pc=%08h", wb_csr_pc);
        tick();
        idle_inputs();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_ale();
        idle_inputs();
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = 6'h09;
        wb_vaddr_in = 32'h00000003; wb_pc = 32'h1c000500; csr_ex_entry = 32'h1c008040;
        @(negedge clk);
        checks++; if (wb_vaddr !== 32'h00000003) begin errors++; $display("FAIL ale_vaddr got=%08h exp=00000003", wb_vaddr); end
        checks++; if (wb_ecode !== 6'h09 || wb_ex !== 1'b1) begin errors++; $display("FAIL ale_ecode got=%02h wb_ex=%0b exp=09,1", wb_ecode, wb_ex); end
        $display("ale: commit pc=%08h vaddr=%08h", wb_csr_pc, wb_vaddr);
        tick();
        idle_inputs();
        redirect_ready = 1'b1;
        @(negedge clk);
        checks++; if (redirect_pc !== 32'h1c008040) begin errors++; $display("FAIL ale_rpc got=%08h exp=1c008040", redirect_pc); end
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_reset_mid_redirect();
        idle_inputs();
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = 6'h0C;
        wb_pc = 32'h1c000600; csr_ex_entry = 32'h1c008000;
        tick();
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_rv_before got=%0b exp=1", redirect_valid); end
        tick();
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0 || flush_all !== 1'b0 || wb_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after rv=%0b flush=%0b ready=%0b exp=0,0,1", redirect_valid, flush_all, wb_ready); end
        tick();
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = 6'h0D;
        wb_pc = 32'h1c000700; csr_ex_entry = 32'h1c009000;
        @(negedge clk);
        checks++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h0D || wb_csr_pc !== 32'h1c000700) begin errors++; $display("FAIL rst_b2b_commit wb_ex=%0b ecode=%02h pc=%08h exp=1,0d,1c000700", wb_ex, wb_ecode, wb_csr_pc); end
        $display("reset_mid_redirect: recommit pc=%08h", wb_csr_pc);
        tick();
        idle_inputs();
        redirect_ready = 1'b1;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c009000) begin errors++; $display("FAIL rst_b2b_rpc rv=%0b rpc=%08h exp=1,1c009000", redirect_valid, redirect_pc); end
        tick();
        redirect_ready = 1'b0;
    endtask

    // Reference model: "busy" means a redirect is pending; "int_prev" is last cycle's interrupt request.
    task automatic test_random();
        bit          m_busy;
        bit          m_int_prev;
        logic [31:0] m_rpc;
        bit          int_now, fire, e_ex, e_ertn;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
        logic [31:0] e_pc, e_va;
        int          commits;
        commits = 0;
        idle_inputs();
        resetn = 1'b0;
        tick();
        m_busy = 1'b0; m_int_prev = 1'b0; m_rpc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            resetn         = ($urandom_range(0, 49) != 0);
            wb_valid       = 1'($urandom_range(0, 1));
            wb_ex_in       = ($urandom_range(0, 3) == 0);
            wb_is_ertn     = ($urandom_range(0, 3) == 0);
            wb_ecode_in    = 6'($urandom);
            wb_esub_in     = 9'($urandom);
            wb_pc          = $urandom;
            wb_vaddr_in    = $urandom;
            csr_crmd_ie    = 1'($urandom_range(0, 1));
            csr_estat_is   = 13'($urandom);
            csr_ecfg_lie   = ($urandom_range(0, 2) == 0) ? 13'($urandom) : 13'h0;
            csr_ex_entry   = $urandom;
            csr_ertn_entry = $urandom;
            redirect_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            int_now = csr_crmd_ie && ((csr_estat_is & csr_ecfg_lie) != 13'h0);
            fire    = !m_busy && wb_valid && (m_int_prev || wb_ex_in || wb_is_ertn);
            e_ex    = fire && (m_int_prev || wb_ex_in);
            e_ertn  = fire && !e_ex;
            e_ecode = !e_ex ? 6'h00 : (m_int_prev ? 6'h00 : wb_ecode_in);
            e_esub  = !e_ex ? 9'h000 : (m_int_prev ? 9'h000 : wb_esub_in);
            e_pc    = fire ? wb_pc : 32'h0;
            e_va    = fire ? wb_vaddr_in : 32'h0;
            checks++; if (wb_ex !== e_ex) begin errors++; $display("FAIL rnd_wb_ex[%0d] got=%0b exp=%0b", c, wb_ex, e_ex); end
            checks++; if (ertn_flush !== e_ertn) begin errors++; $display("FAIL rnd_ertn[%0d] got=%0b exp=%0b", c, ertn_flush, e_ertn); end
            checks++; if (wb_ecode !== e_ecode || wb_esubcode !== e_esub) begin errors++; $display("FAIL rnd_code[%0d] got=%02h/%03h exp=%02h/%03h", c, wb_ecode, wb_esubcode, e_ecode, e_esub); end
            checks++; if (wb_csr_pc !== e_pc || wb_vaddr !== e_va) begin errors++; $display("FAIL rnd_pcva[%0d] got=%08h/%08h exp=%08h/%08h", c, wb_csr_pc, wb_vaddr, e_pc, e_va); end
            checks++; if (flush_all !== (fire || m_busy)) begin errors++; $display("FAIL rnd_flush[%0d] got=%0b exp=%0b", c, flush_all, fire || m_busy); end
            checks++; if (redirect_valid !== m_busy || wb_ready !== !m_busy) begin errors++; $display("FAIL rnd_hs[%0d] rv=%0b ready=%0b exp=%0b,%0b", c, redirect_valid, wb_ready, m_busy, !m_busy); end
            checks++; if (redirect_pc !== m_rpc) begin errors++; $display("FAIL rnd_rpc[%0d] got=%08h exp=%08h", c, redirect_pc, m_rpc); end
            if (fire) commits++;
            if (!resetn) begin
                m_busy = 1'b0; m_int_prev = 1'b0; m_rpc = 32'h0;
            end else begin
                if (m_busy) begin
                    m_busy = !redirect_ready;
                end else if (fire) begin
                    m_busy = 1'b1;
                    m_rpc  = e_ex ? csr_ex_entry : csr_ertn_entry;
                end
                m_int_prev = int_now;
            end
            tick();
        end
        $display("random: 400 cycles, %0d commits", commits);
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_syscall();
        test_ertn();
        test_int_priority();
        test_int_mask_timing();
        test_ale();
        test_reset_mid_redirect();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
Commit-point controller that sequences exceptions, interrupts and ERTN between the WB stage and the CSR file. It fuses pending interrupts with instruction exceptions, picks one winner per committing instruction, and drives the CSR update strobes (wb_ex, ertn_flush with ecode/esubcode/pc/vaddr). It then holds the pipeline flushed while a redirect to the exception entry or return address is handshaken with the fetch stage.

Parameters:
ECODE_INT, 6'h00, ecode reported for an interrupt
IRQ_W, 13, width of ESTAT.IS / ECFG.LIE vectors

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
wb_valid  in  1  WB holds an instruction attempting commit this cycle
wb_pc  in  32  PC of WB instruction
wb_ex_in  in  1  WB instruction carries an exception
wb_ecode_in  in  6  its ecode
wb_esub_in  in  9  its esubcode
wb_vaddr_in  in  32  faulting data address (ALE/ADE-mem)
wb_is_ertn  in  1  WB instruction is ERTN
wb_ready  out  1  WB may commit; 0 while a redirect is outstanding
csr_crmd_ie  in  1  CRMD.IE
csr_estat_is  in  IRQ_W  ESTAT.IS
csr_ecfg_lie  in  IRQ_W  ECFG.LIE
csr_ex_entry  in  32  exception entry from CSR file
csr_ertn_entry  in  32  ERA from CSR file
wb_ex  out  1  one-cycle exception commit strobe to CSR file
wb_ecode  out  6  ecode to CSR file
wb_esubcode  out  9  esubcode to CSR file
wb_csr_pc  out  32  PC written to ERA
wb_vaddr  out  32  address for BADV
ertn_flush  out  1  one-cycle ERTN commit strobe to CSR file
flush_all  out  1  squash IF..MEM
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, int_sync=0, redirect_pc=0. All strobes/valids are 0. wb_ready=1 after reset. Reset mid-REDIRECT abandons the redirect.
- int_raw = csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie). It is registered into int_sync each cycle. An interrupt visible at cycle N can be taken no earlier than cycle N+1.
- States: IDLE, REDIRECT.
- IDLE, commit = wb_valid & (int_sync | wb_ex_in | wb_is_ertn). Priority, first match wins:
  1) int_sync: wb_ex=1, ecode=ECODE_INT, esub=0.
  2) wb_ex_in: wb_ex=1, ecode/esub=wb_ecode_in/wb_esub_in.
  3) wb_is_ertn: ertn_flush=1.
- On the commit cycle:
  - wb_csr_pc=wb_pc and wb_vaddr=wb_vaddr_in, both combinational.
  - flush_all=1 in the same cycle.
  - redirect_pc <= csr_ex_entry for an exception/interrupt, or csr_ertn_entry for ERTN. It samples the pre-update CSR values.
  - Next state is REDIRECT.
- wb_ex and ertn_flush are never both 1. Each lasts exactly one cycle per commit.
- IDLE with no commit: no strobes, flush_all=0, wb_ready=1.
- wb_valid=0 with int_sync=1: nothing happens; the interrupt waits for the next valid WB instruction.
- REDIRECT:
  - redirect_valid=1 and flush_all=1; wb_ready=0; no strobes.
  - redirect_pc is stable until accepted.
  - On redirect_ready=1: transfer completes and state returns to IDLE next cycle.
  - redirect_ready while in IDLE is ignored.
  - A commit is therefore possible no earlier than 2 cycles after the prior commit. Because IE is cleared by the CSR file, int_sync cannot retrigger.
- wb_ex_in or wb_is_ertn with wb_valid=0 is ignored.
- wb_ecode/wb_esubcode/wb_vaddr/wb_csr_pc are don't-care when both strobes are 0. The driven value is 0 in that case.

Decomposition:
- Shared package/defines: ECODE_* values (INT 0x00, ADE 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D), ESUB_* values, and the state encoding (IDLE=1'b0, REDIRECT=1'b1).
- One natural sub-module: exc_prio_sel. It is purely combinational and does the winner selection (interrupt / exception / ertn, ecode/esub mux). The FSM and redirect register stay in the top.

Test Plan:
- SYSCALL: wb_valid=1, wb_ex_in=1, ecode=0x0B, wb_pc=0x1c000100, csr_ex_entry=0x1c008000. Expect: wb_ex=1 for 1 cycle with ecode 0x0B and wb_csr_pc=0x1c000100. Then redirect_valid=1, redirect_pc=0x1c008000 held across 3 cycles of redirect_ready=0, and wb_ready=0 throughout. IDLE follows the cycle after ready.
- ERTN: wb_is_ertn=1, csr_ertn_entry=0x1c000104. Expect: ertn_flush=1 for 1 cycle, wb_ex=0, then redirect_pc=0x1c000104.
- Interrupt priority: IE=1, IS[11]=1, LIE[11]=1 for ≥1 cycle, then a WB instruction with wb_ex_in=1, ecode 0x0D. Expect: ecode=0x00, esub=0, pc=that instruction's PC.
- Interrupt masking/timing: IS[2]=1 with LIE[2]=0 → no interrupt. Set LIE[2]=1 at cycle N → the interrupt is not taken at cycle N but is taken at the first wb_valid at or after N+1. The same interrupt with wb_valid=0 produces no strobe.
- ALE: ecode 0x09, wb_vaddr_in=0x00000003. Expect: wb_vaddr=0x00000003 on the strobe cycle.
- Reset asserted during REDIRECT → next cycle redirect_valid=0, flush_all=0, wb_ready=1. A back-to-back exception then commits normally.
